comparador_checker: RTL and testbench

Self-checking sweep engine for the 4-bit composite-number detector (`Comparador`). It drives the detector's inputs with every code 0..15 exactly once, waits a programmable settle time per code, and samples the detector output `S`. It then compares `S` against an expected-response mask and reports pass/fail, the mismatch count and the first failing code. It lets the detector be verified on hardware or in a bench without a hand-written stimulus loop.

---
 rtl/comparador_checker.sv | 116 +++++++++++
 tb/tb_comparador_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparador_checker.sv
// Self-checking sweep engine for the 4-bit composite-number detector.
// Optional build macro: COMPARADOR_CHK_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module comparador_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECT_MASK   = 16'hD750
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  input  logic       S,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       first_err_valid,
  output logic [3:0] first_err_code
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] code;
  logic [7:0] settle_cnt;
  logic       mismatch;
  logic       last_code;

  // The detector sees the registered code directly, so A..D are glitch-free.
  assign {A, B, C, D} = code;
  assign mismatch     = (S != EXPECT_MASK[code]);

`ifdef COMPARADOR_CHK_STOP_ON_ERR_EN
  assign last_code = (code == 4'd15) || mismatch;
`else
  assign last_code = (code == 4'd15);
`endif

  // NOTE: every register here is state, so all updates are non-blocking and
  // the reset branch is level-checked to take effect asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      code            <= 4'd0;
      settle_cnt      <= 8'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= 5'd0;
      first_err_valid <= 1'b0;
      first_err_code  <= 4'd0;
    end else begin
      // NOTE: done defaults low each edge so it can only ever be a single-cycle pulse.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= SETTLE;
            code            <= 4'd0;
            settle_cnt      <= SETTLE_RELOAD;
            busy            <= 1'b1;
            pass            <= 1'b0;
            err_count       <= 5'd0;
            first_err_valid <= 1'b0;
            first_err_code  <= 4'd0;
          end
        end

        SETTLE: begin
          if (settle_cnt == 8'd0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end

        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 5'd1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_code  <= code;
            end
          end
          if (last_code) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= SETTLE;
            code       <= code + 4'd1;
            settle_cnt <= SETTLE_RELOAD;
          end
        end

        DONE: begin
          // err_count already includes the final SAMPLE update at this point.
          pass  <= (err_count == 5'd0);
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_checker.sv
// Bench for comparador_checker: timing-level reference model checked every cycle,
// plus directed sweeps with hand-computed results.
module tb_comparador_checker;

  localparam int          SC   = 4;
  localparam logic [15:0] MASK = 16'hD750;
  localparam int          HOLD = SC + 1;

  logic       clk;
  logic       rst;
  logic       start;
  logic       A, B, C, D;
  logic       S;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic       first_err_valid;
  logic [3:0] first_err_code;

  int s_mode;  // 0 = correct detector, 1 = stuck at 0, 2 = inverted
  int n_cmp;
  int n_fail;

  comparador_checker #(
    .SETTLE_CYCLES(SC),
    .EXPECT_MASK  (MASK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .A              (A),
    .B              (B),
    .C              (C),
    .D              (D),
    .S              (S),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_valid(first_err_valid),
    .first_err_code (first_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic s_model(input int mode, input int c);
    logic [15:0] m;
    m = MASK;
    case (mode)
      1:       return 1'b0;
      2:       return ~m[c];
      default: return m[c];
    endcase
  endfunction

  assign S = s_model(s_mode, int'({A, B, C, D}));

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a sweep accepted at edge k is a pure function of time since k.
  typedef struct {
    int last;
    int first;
    int prefix[17];
  } plan_t;

  function automatic plan_t make_plan(input int mode);
    plan_t p;
    logic [15:0] m;
    int acc;
    m = MASK;
    acc = 0;
    p.first = -1;
    p.last = 15;
    p.prefix[0] = 0;
    for (int c = 0; c < 16; c++) begin
      if (s_model(mode, c) != m[c]) begin
        acc++;
        if (p.first < 0) p.first = c;
      end
      p.prefix[c+1] = acc;
    end
`ifdef COMPARADOR_CHK_STOP_ON_ERR_EN
    if (p.first >= 0) p.last = p.first;
`endif
    return p;
  endfunction

  bit    have_sweep;
  int    edge_n;
  int    k_edge;
  plan_t plan;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      have_sweep <= 1'b0;
      edge_n     <= 0;
      k_edge     <= 0;
    end else begin
      edge_n <= edge_n + 1;
      if (start && (!have_sweep ||
                    (edge_n + 1 - k_edge) >= (plan.last + 1) * HOLD + 2)) begin
        have_sweep <= 1'b1;
        k_edge     <= edge_n + 1;
        plan       <= make_plan(s_mode);
      end
    end
  end

  always @(negedge clk) begin
    int rel, dur, n;
    int e_code, e_busy, e_done, e_pass, e_err, e_fev, e_fec;
    e_code = 0; e_busy = 0; e_done = 0; e_pass = 0; e_err = 0; e_fev = 0; e_fec = 0;
    if (have_sweep && !rst) begin
      rel = edge_n - k_edge;
      dur = (plan.last + 1) * HOLD;
      if (rel < dur) begin
        e_code = rel / HOLD;
        e_busy = 1;
      end else begin
        e_code = plan.last;
        e_done = (rel == dur) ? 1 : 0;
      end
      n = rel / HOLD;
      if (n > plan.last + 1) n = plan.last + 1;
      e_err = plan.prefix[n];
      e_fev = (plan.first >= 0 && plan.first < n) ? 1 : 0;
      e_fec = e_fev ? plan.first : 0;
      e_pass = (rel > dur && plan.prefix[plan.last+1] == 0) ? 1 : 0;
    end
    check("code",            int'({A, B, C, D}),  e_code);
    check("busy",            int'(busy),          e_busy);
    check("done",            int'(done),          e_done);
    check("pass",            int'(pass),          e_pass);
    check("err_count",       int'(err_count),     e_err);
    check("first_err_valid", int'(first_err_valid), e_fev);
    check("first_err_code",  int'(first_err_code),  e_fec);
  end

  // Pulse start for one edge and count edges until done is seen.
  task automatic run_sweep(output int edges);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    start = 1'b0;
    while (!done && edges < 300) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("done_seen", int'(done), 1);
    @(negedge clk);
  endtask

  task automatic check_final(input string tag, input int e_err, input int e_fev,
                             input int e_fec, input int e_pass, input int e_code);
    check({tag, "_err_count"}, int'(err_count),       e_err);
    check({tag, "_fev"},       int'(first_err_valid), e_fev);
    if (e_fev != 0) check({tag, "_fec"}, int'(first_err_code), e_fec);
    check({tag, "_pass"},      int'(pass),            e_pass);
    check({tag, "_code"},      int'({A, B, C, D}),    e_code);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int dones;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    start  = 1'b0;
    s_mode = 0;
    repeat (2) @(negedge clk);
    check("reset_code", int'({A, B, C, D}), 0);
    check("reset_pass", int'(pass), 0);
    rst = 1'b0;

    // Correct detector: full sweep, clean pass.
    s_mode = 0;
    run_sweep(edges);
    check("lat_model", edges, 80);
    check_final("model", 0, 0, 0, 1, 15);

    // Stuck-at-0 detector.
    s_mode = 1;
    run_sweep(edges);
`ifdef COMPARADOR_CHK_STOP_ON_ERR_EN
    check("lat_stuck0", edges, 25);
    check_final("stuck0", 1, 1, 4, 0, 4);
`else
    check("lat_stuck0", edges, 80);
    check_final("stuck0", 8, 1, 4, 0, 15);
`endif

    // Inverted detector.
    s_mode = 2;
    run_sweep(edges);
`ifdef COMPARADOR_CHK_STOP_ON_ERR_EN
    check("lat_inv", edges, 5);
    check_final("inv", 1, 1, 0, 0, 0);
`else
    check("lat_inv", edges, 80);
    check_final("inv", 16, 1, 0, 0, 15);
`endif

    // Asynchronous reset in the middle of code 7.
    s_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while ({A, B, C, D} != 4'd7 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check("reached_code7", int'({A, B, C, D}), 7);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("arst_code", int'({A, B, C, D}), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_pass", int'(pass), 0);
    check("arst_err",  int'(err_count), 0);
    check("arst_fev",  int'(first_err_valid), 0);
    check("arst_fec",  int'(first_err_code), 0);
    run_sweep(edges);
    check("lat_after_rst", edges, 80);
    check_final("after_rst", 0, 0, 0, 1, 15);

    // start held high: back-to-back sweeps, two completions inside 200 cycles.
    @(negedge clk);
    start = 1'b1;
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    check("held_start_dones", dones, 2);
    edges = 0;
    while (!done && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    check("held_final_done", int'(done), 1);
    @(negedge clk);
    check_final("held", 0, 0, 0, 1, 15);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
